// File: rtl/python_sync_encoder_pkg.sv
// Shared definitions for the PYTHON sync-channel encoder: sync codes, FSM states
// and the per-lane CRC-8 step (poly 0x07, MSB first).
package python_sync_encoder_pkg;

    localparam logic [7:0] SYNC_FS  = 8'haa;
    localparam logic [7:0] SYNC_LS  = 8'h2a;
    localparam logic [7:0] SYNC_FE  = 8'hca;
    localparam logic [7:0] SYNC_LE  = 8'h4a;
    localparam logic [7:0] SYNC_IMG = 8'h35;
    localparam logic [7:0] SYNC_BL  = 8'h15;
    localparam logic [7:0] SYNC_CRC = 8'h59;
    localparam logic [7:0] SYNC_TR  = 8'he9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_SKIP  = 2'd2
    } enc_state_e;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] acc;
        acc = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            if (acc[7]) begin
                acc = {acc[6:0], 1'b0} ^ 8'h07;
            end else begin
                acc = {acc[6:0], 1'b0};
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/python_sync_encoder_crc8_lane.sv
// One byte lane of the per-line CRC-8. clr restarts from zero; a word arriving
// in the same cycle as clr is folded into the fresh CRC.
module python_crc8_lane
    import python_sync_encoder_pkg::*;
(
    input  logic       c,
    input  logic       rst_n,
    input  logic [7:0] d,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] crc
);

    logic [7:0] base_s;

    // Select the CRC seed: restart value or running value.
    always_comb begin
        if (clr) begin
            base_s = 8'h00;
        end else begin
            base_s = crc;
        end
    end

    // Running CRC register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(base_s, d);
        end else begin
            crc <= base_s;
        end
    end

endmodule

// File: rtl/python_sync_encoder.sv
// PYTHON-style sync/data channel encoder: one stage register gives a one-slot
// lookahead for tagging line ends; the output register adds the second cycle.
module python_sync_encoder
    import python_sync_encoder_pkg::*;
#(
    parameter int         ROWS          = 64,
    parameter int         COLS          = 1280,
    parameter logic [7:0] TRAIN_PATTERN = 8'h3a
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        en,
    input  logic        fv,
    input  logic        lv,
    input  logic [31:0] d,
    output logic [31:0] data,
    output logic [7:0]  sync,
    output logic [1:0]  err,
    input  logic        clr_err
);

    localparam logic [10:0] LAST_ROW   = 11'(ROWS - 1);
    localparam logic [11:0] ROWS_W     = 12'(ROWS);
    localparam logic [9:0]  LINE_WORDS = 10'(COLS / 4);

    enc_state_e  state_r, state_nxt_s;
    logic        fv_prev_r;
    logic        st_word_r, st_first_r, st_crc_r, st_frame_r;
    logic [31:0] st_d_r;
    logic [10:0] row_r;
    logic [9:0]  word_r;
    logic [31:0] crc_s;
    logic        fv_rise_s, in_frame_s, word_s, line_end_s, frame_end_s;
    logic [11:0] rows_done_s;
    logic [1:0]  err_evt_s;
    logic [7:0]  sync_nxt_s;
    logic [31:0] data_nxt_s;

    assign fv_rise_s   = fv & ~fv_prev_r;
    assign word_s      = in_frame_s & lv;
    assign line_end_s  = st_word_r & ~word_s;
    assign frame_end_s = (state_r == ST_FRAME) & ~fv;
    // A line cut short by fv falling has not yet been counted in row_r.
    assign rows_done_s = {1'b0, row_r} + {11'd0, st_word_r};
    assign err_evt_s   = {line_end_s & (word_r != LINE_WORDS),
                          frame_end_s & (rows_done_s != ROWS_W)};

    // Frame FSM next state and per-slot frame membership.
    always_comb begin
        state_nxt_s = state_r;
        in_frame_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fv_rise_s && en) begin
                    state_nxt_s = ST_FRAME;
                    in_frame_s  = 1'b1;
                end else if (fv_rise_s) begin
                    state_nxt_s = ST_SKIP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (fv) begin
                    in_frame_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SKIP: begin
                if (!fv) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SKIP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, fv history and stage register. fv_prev resets high so a frame
    // already in progress when reset lifts is not mistaken for a new one.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            fv_prev_r  <= 1'b1;
            st_word_r  <= 1'b0;
            st_first_r <= 1'b0;
            st_crc_r   <= 1'b0;
            st_frame_r <= 1'b0;
            st_d_r     <= 32'h0;
        end else begin
            state_r    <= state_nxt_s;
            fv_prev_r  <= fv;
            st_word_r  <= word_s;
            st_first_r <= word_s & ~st_word_r;
            st_crc_r   <= line_end_s;
            st_frame_r <= in_frame_s;
            st_d_r     <= d;
        end
    end

    // Saturating row/word counters and sticky error flags.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            row_r  <= 11'd0;
            word_r <= 10'd0;
            err    <= 2'b00;
        end else begin
            if (frame_end_s) begin
                row_r <= 11'd0;
            end else if (line_end_s && (row_r != 11'h7ff)) begin
                row_r <= row_r + 11'd1;
            end else begin
                row_r <= row_r;
            end
            if (line_end_s) begin
                word_r <= 10'd0;
            end else if (word_s && (word_r != 10'h3ff)) begin
                word_r <= word_r + 10'd1;
            end else begin
                word_r <= word_r;
            end
            if (clr_err) begin
                err <= err_evt_s;
            end else begin
                err <= err | err_evt_s;
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        python_crc8_lane u_lane (
            .c     (c),
            .rst_n (rst_n),
            .d     (d[8*k +: 8]),
            .clr   (st_crc_r),
            .en    (word_s),
            .crc   (crc_s[8*k +: 8])
        );
    end

    // Tag the staged slot using the current slot as lookahead.
    always_comb begin
        sync_nxt_s = SYNC_TR;
        data_nxt_s = {4{TRAIN_PATTERN}};
        if (st_word_r) begin
            data_nxt_s = st_d_r;
            if (!word_s) begin
                sync_nxt_s = (row_r == LAST_ROW) ? SYNC_FE : SYNC_LE;
            end else if (st_first_r) begin
                sync_nxt_s = (row_r == 11'd0) ? SYNC_FS : SYNC_LS;
            end else begin
                sync_nxt_s = SYNC_IMG;
            end
        end else if (st_crc_r) begin
            sync_nxt_s = SYNC_CRC;
            data_nxt_s = crc_s;
        end else if (st_frame_r) begin
            sync_nxt_s = SYNC_BL;
            data_nxt_s = 32'h0;
        end else begin
            sync_nxt_s = SYNC_TR;
            data_nxt_s = {4{TRAIN_PATTERN}};
        end
    end

    // Output register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sync <= SYNC_TR;
            data <= {4{TRAIN_PATTERN}};
        end else begin
            sync <= sync_nxt_s;
            data <= data_nxt_s;
        end
    end

endmodule

// File: tb/tb_python_sync_encoder.sv
// Directed bench for python_sync_encoder: a slot-history model derives every
// output from line/frame structure; literal checks pin the model itself.
module tb_python_sync_encoder;

    localparam int ROWS = 2;
    localparam int COLS = 16;
    localparam int N    = 1024;
    localparam logic [7:0]  K_FS = 8'haa, K_LS = 8'h2a, K_FE = 8'hca, K_LE = 8'h4a;
    localparam logic [7:0]  K_IMG = 8'h35, K_BL = 8'h15, K_CRC = 8'h59, K_TR = 8'he9;
    localparam logic [31:0] TRAIN = 32'h3a3a3a3a;

    logic        c = 1'b0;
    logic        rst_n, en, fv, lv, clr_err;
    logic [31:0] d;
    logic [31:0] data;
    logic [7:0]  sync;
    logic [1:0]  err;

    always #5 c = ~c;

    python_sync_encoder #(.ROWS(ROWS), .COLS(COLS), .TRAIN_PATTERN(8'h3a)) dut (
        .c(c), .rst_n(rst_n), .en(en), .fv(fv), .lv(lv), .d(d),
        .data(data), .sync(sync), .err(err), .clr_err(clr_err)
    );

    logic        h_fv [N];
    logic        h_lv [N];
    logic        h_rst [N];
    logic        h_frame [N];
    logic [31:0] h_d [N];
    logic [7:0]  cap_sync [N];
    logic [31:0] cap_data [N];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        frame_on = 1'b0;

    // Record each input slot; a frame is live from an enabled fv rise until fv drops.
    always @(posedge c) begin
        if (!rst_n) begin
            frame_on = 1'b0;
            h_rst[cyc] = 1'b1;
        end else begin
            h_rst[cyc] = 1'b0;
            if (!fv) begin
                frame_on = 1'b0;
            end else if (cyc > 0 && !h_fv[cyc-1] && !h_rst[cyc-1] && en) begin
                frame_on = 1'b1;
            end
        end
        h_fv[cyc]    = fv & rst_n;
        h_lv[cyc]    = lv;
        h_d[cyc]     = d;
        h_frame[cyc] = frame_on;
        cyc = cyc + 1;
    end

    function automatic bit is_word(int i);
        if (i < 0) return 1'b0;
        return h_frame[i] && h_lv[i];
    endfunction

    function automatic logic [31:0] line_crc(int first, int last);
        logic [7:0]  cr [4];
        logic [31:0] w;
        logic        fb;
        for (int k = 0; k < 4; k++) cr[k] = 8'h00;
        for (int j = first; j <= last; j++) begin
            w = h_d[j];
            for (int k = 0; k < 4; k++) begin
                for (int b = 7; b >= 0; b--) begin
                    fb = cr[k][7] ^ w[8*k + b];
                    cr[k] = {cr[k][6:0], 1'b0};
                    if (fb) cr[k] = cr[k] ^ 8'h07;
                end
            end
        end
        return {cr[3], cr[2], cr[1], cr[0]};
    endfunction

    // Expected {sync, data} for slot s, looking one slot ahead.
    function automatic logic [39:0] expect_slot(int s);
        int row;
        int j;
        if (h_rst[s] || h_rst[s+1]) return {K_TR, TRAIN};
        if (is_word(s)) begin
            row = 0;
            for (j = s - 1; j >= 0 && h_frame[j]; j--) begin
                if (is_word(j) && !is_word(j + 1)) row++;
            end
            if (!is_word(s + 1)) return {(row == ROWS - 1) ? K_FE : K_LE, h_d[s]};
            if (!is_word(s - 1)) return {(row == 0) ? K_FS : K_LS, h_d[s]};
            return {K_IMG, h_d[s]};
        end
        if (is_word(s - 1)) begin
            j = s - 1;
            while (j > 0 && is_word(j - 1)) j--;
            return {K_CRC, line_crc(j, s - 1)};
        end
        if (h_frame[s]) return {K_BL, 32'h0};
        return {K_TR, TRAIN};
    endfunction

    // Every cycle: output now visible belongs to slot cyc-2.
    always @(negedge c) begin : cmp
        logic [39:0] e;
        int s;
        if (cyc >= 2) begin
            s = cyc - 2;
            if (!rst_n) e = {K_TR, TRAIN};
            else e = expect_slot(s);
            cap_sync[s] = sync;
            cap_data[s] = data;
            checks++;
            if (sync !== e[39:32] || data !== e[31:0]) begin
                failures++;
                $display("FAIL stream slot %0d: got sync=%h data=%h, expected sync=%h data=%h",
                         s, sync, data, e[39:32], e[31:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic slot(input logic f, input logic l, input logic [31:0] w);
        fv = f;
        lv = l;
        d  = w;
        @(posedge c);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) slot(1'b0, 1'b0, 32'h0);
    endtask

    logic [7:0] exp1 [13];
    int t;

    initial begin
        exp1 = '{K_FS, K_IMG, K_IMG, K_LE, K_CRC, K_BL, K_BL,
                 K_LS, K_IMG, K_IMG, K_FE, K_CRC, K_TR};
        rst_n = 1'b0; en = 1'b1; fv = 1'b0; lv = 1'b0; d = 32'h0; clr_err = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        chk("reset_sync", {24'h0, sync}, {24'h0, K_TR});
        chk("reset_data", data, TRAIN);
        chk("reset_err", {30'h0, err}, 32'h0);

        // Two 4-word lines, 3-slot gap, frame ends after second line.
        t = cyc;
        for (int k = 0; k < 4; k++) slot(1'b1, 1'b1, 32'h11223300 + k);
        for (int k = 0; k < 3; k++) slot(1'b1, 1'b0, 32'hdeadbeef);
        for (int k = 0; k < 4; k++) slot(1'b1, 1'b1, 32'ha0b0c000 + k);
        idle(5);
        for (int k = 0; k < 13; k++) chk("t1_seq", {24'h0, cap_sync[t+k]}, {24'h0, exp1[k]});
        chk("t1_first_data", cap_data[t], 32'h11223300);
        chk("t1_err", {30'h0, err}, 32'h0);

        // Zero line, 1-slot gap, {01}x4 line.
        t = cyc;
        for (int k = 0; k < 4; k++) slot(1'b1, 1'b1, 32'h0);
        slot(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) slot(1'b1, 1'b1, 32'h01010101);
        slot(1'b1, 1'b0, 32'h0);
        idle(4);
        chk("t2_crc_zero_sync", {24'h0, cap_sync[t+4]}, {24'h0, K_CRC});
        chk("t2_crc_zero", cap_data[t+4], 32'h0);
        chk("t3_ls_after_crc", {24'h0, cap_sync[t+5]}, {24'h0, K_LS});
        chk("t3_ls_data", cap_data[t+5], 32'h01010101);
        chk("t2_fe", {24'h0, cap_sync[t+8]}, {24'h0, K_FE});
        chk("t2_crc_ones", cap_data[t+9], 32'h6f6f6f6f);
        chk("t2_err", {30'h0, err}, 32'h0);

        // One row only; fv and lv fall together.
        t = cyc;
        for (int k = 0; k < 4; k++) slot(1'b1, 1'b1, 32'h00000010 + k);
        idle(4);
        chk("t4_le", {24'h0, cap_sync[t+3]}, {24'h0, K_LE});
        chk("t4_crc", {24'h0, cap_sync[t+4]}, {24'h0, K_CRC});
        chk("t4_tr", {24'h0, cap_sync[t+5]}, {24'h0, K_TR});
        chk("t4_err", {30'h0, err}, 32'h1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("t4_clr", {30'h0, err}, 32'h0);

        // Set err again, then reset mid-line.
        for (int k = 0; k < 4; k++) slot(1'b1, 1'b1, 32'h55550000 + k);
        idle(3);
        chk("t6_pre_err", {30'h0, err}, 32'h1);
        for (int k = 0; k < 2; k++) slot(1'b1, 1'b1, 32'h77770000 + k);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sync", {24'h0, sync}, {24'h0, K_TR});
        chk("t6_rst_data", data, TRAIN);
        chk("t6_rst_err", {30'h0, err}, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // Frame with en low is suppressed.
        en = 1'b0;
        t = cyc;
        for (int k = 0; k < 4; k++) slot(1'b1, 1'b1, 32'h99990000 + k);
        slot(1'b1, 1'b0, 32'h0);
        idle(4);
        chk("t6_skip_sync", {24'h0, cap_sync[t]}, {24'h0, K_TR});
        chk("t6_skip_crc", {24'h0, cap_sync[t+4]}, {24'h0, K_TR});
        chk("t6_skip_err", {30'h0, err}, 32'h0);
        en = 1'b1;

        // Short single-row frame ending in the same slot as clr_err: event wins.
        for (int k = 0; k < 3; k++) slot(1'b1, 1'b1, 32'h0000abc0 + k);
        clr_err = 1'b1;
        slot(1'b0, 1'b0, 32'h0);
        clr_err = 1'b0;
        chk("clr_vs_event", {30'h0, err}, 32'h3);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("clr_after", {30'h0, err}, 32'h0);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
